// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: 2-bit saturating counters indexed by PC[IDX_W+1:2].
// Optional macro BP_PERF_CNT_EN adds branch and misprediction event counters.
module branch_predictor #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_req,
    input  logic [31:0] pred_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_pred,
    output logic        mispredict
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispred
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       ctr_q [ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_old;
    logic [1:0]       upd_new;
    logic [1:0]       pred_ctr;
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic             mispredict_q, mispredict_d;
    logic             unused_pc_bits;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                              upd_pc[31:IDX_W+2], upd_pc[1:0]};

    always_comb begin
        upd_old = ctr_q[upd_idx];
        upd_new = upd_old;
        if (upd_taken) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
        end
    end

    // Write-first: a same-cycle update to the requested entry is visible to the prediction.
    always_comb begin
        pred_ctr = ctr_q[pred_idx];
        if (upd_valid && (upd_idx == pred_idx)) pred_ctr = upd_new;
    end

    always_comb begin
        pred_valid_d = pred_req;
        pred_taken_d = pred_taken_q;
        if (pred_req) pred_taken_d = pred_ctr[1];
        mispredict_d = upd_valid & (upd_taken ^ upd_pred);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_CTR;
        end else if (upd_valid) begin
            ctr_q[upd_idx] <= upd_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign mispredict = mispredict_q;

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches_q, perf_branches_d;
    logic [31:0] perf_mispred_q,  perf_mispred_d;

    always_comb begin
        perf_branches_d = perf_branches_q;
        perf_mispred_d  = perf_mispred_q;
        if (upd_valid)    perf_branches_d = perf_branches_q + 32'd1;
        if (mispredict_d) perf_mispred_d  = perf_mispred_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_q <= 32'd0;
            perf_mispred_q  <= 32'd0;
        end else begin
            perf_branches_q <= perf_branches_d;
            perf_mispred_q  <= perf_mispred_d;
        end
    end

    assign perf_branches = perf_branches_q;
    assign perf_mispred  = perf_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a counter-array reference model.
module tb_branch_predictor;
    localparam int IDX_W   = 6;
    localparam int ENTRIES = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = 32'd0;
    logic        pred_valid, pred_taken;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic        upd_pred = 1'b0;
    logic        mispredict;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispred;
`endif

    branch_predictor #(.IDX_W(IDX_W), .INIT_CTR(2'b01)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_pred(upd_pred),
        .mispredict(mispredict)
`ifdef BP_PERF_CNT_EN
        , .perf_branches(perf_branches), .perf_mispred(perf_mispred)
`endif
    );

    always #5 clk = ~clk;

    int model [ENTRIES];
    bit exp_valid, exp_taken, exp_mis;
    int exp_branches, exp_mispred;
    int total = 0;
    int bad = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) model[i] = 1;
        exp_valid = 0; exp_taken = 0; exp_mis = 0;
        exp_branches = 0; exp_mispred = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        pred_req = 0; upd_valid = 0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus; outputs are settled #1 after the edge on return.
    task automatic drive(input bit preq, input logic [31:0] ppc, input bit uv,
                         input logic [31:0] upc, input bit ut, input bit up);
        int i;
        pred_req = preq; pred_pc = ppc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_pred = up;
        if (uv) begin
            i = idx_of(upc);
            model[i] = ut ? ((model[i] == 3) ? 3 : model[i] + 1)
                          : ((model[i] == 0) ? 0 : model[i] - 1);
            exp_branches++;
        end
        exp_mis = uv && (ut != up);
        if (exp_mis) exp_mispred++;
        exp_valid = preq;
        if (preq) exp_taken = (model[idx_of(ppc)] >= 2);
        @(posedge clk);
        #1;
        pred_req = 0; upd_valid = 0;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        total += 3;
        if (pred_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pred_valid); end
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", pred_taken); end
        if (mispredict !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", mispredict); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h100, 0, 0, 0, 0);
        total += 2;
        if (pred_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", pred_valid); end
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL first_taken got=%b exp=0", pred_taken); end
        drive(0, 0, 0, 0, 0, 0);
        total += 2;
        if (pred_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", pred_valid); end
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL idle_hold got=%b exp=0", pred_taken); end
        $display("test_reset: checks=%0d bad=%0d", total, bad);
    endtask

    task automatic test_saturation();
        bit seq [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        bit want [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        for (int k = 0; k < 9; k++) begin
            drive(0, 0, 1, 32'h100, seq[k], seq[k]);
            drive(1, 32'h100, 0, 0, 0, 0);
            total++;
            if (pred_taken !== want[k] || exp_taken !== want[k]) begin
                bad++;
                $display("FAIL sat_step%0d got=%b exp=%b", k, pred_taken, want[k]);
            end
            $display("sat step %0d upd_taken=%b pred_taken=%b", k, seq[k], pred_taken);
        end
    endtask

    task automatic test_bypass();
        apply_reset();
        drive(1, 32'h200, 1, 32'h200, 1, 0);
        total += 3;
        if (pred_valid !== 1'b1) begin bad++; $display("FAIL bypass_valid got=%b exp=1", pred_valid); end
        if (pred_taken !== 1'b1) begin bad++; $display("FAIL bypass_same got=%b exp=1", pred_taken); end
        if (mispredict !== 1'b1) begin bad++; $display("FAIL bypass_mis got=%b exp=1", mispredict); end
        apply_reset();
        drive(1, 32'h200, 1, 32'h204, 1, 1);
        total += 2;
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL bypass_diff got=%b exp=0", pred_taken); end
        if (mispredict !== 1'b0) begin bad++; $display("FAIL bypass_diff_mis got=%b exp=0", mispredict); end
        drive(1, 32'h204, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b1) begin bad++; $display("FAIL bypass_diff_upd got=%b exp=1", pred_taken); end
        $display("test_bypass: done");
    endtask

    task automatic test_alias();
        apply_reset();
        drive(0, 0, 1, 32'h004, 1, 1);
        drive(0, 0, 1, 32'h004, 1, 1);
        drive(1, 32'h104, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias got=%b exp=1", pred_taken); end
        drive(1, 32'h108, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_neighbor got=%b exp=0", pred_taken); end
        $display("test_alias: pred_taken(0x104)=1 expected");
    endtask

    task automatic test_mispredict();
        bit ut [6]   = '{1, 0, 0, 1, 0, 1};
        bit up [6]   = '{0, 0, 0, 0, 1, 1};
        bit want [6] = '{1, 0, 0, 1, 1, 0};
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 1, 32'h40 + 32'(k * 4), ut[k], up[k]);
            total++;
            if (mispredict !== want[k]) begin
                bad++;
                $display("FAIL mis_step%0d got=%b exp=%b", k, mispredict, want[k]);
            end
            $display("mis step %0d taken=%b pred=%b mispredict=%b", k, ut[k], up[k], mispredict);
        end
        drive(0, 0, 0, 0, 0, 0);
        total++;
        if (mispredict !== 1'b0) begin bad++; $display("FAIL mis_idle got=%b exp=0", mispredict); end
    endtask

    task automatic test_random();
        logic [31:0] ppc, upc;
        bit preq, uv, ut, up;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            preq = $urandom_range(0, 3) != 0;
            uv   = $urandom_range(0, 2) != 0;
            ut   = $urandom_range(0, 1) != 0;
            up   = $urandom_range(0, 1) != 0;
            ppc  = {$urandom_range(0, 255), 2'b00} ^ ($urandom & 32'hFFFF_FF03);
            ppc[IDX_W+1:2] = IDX_W'($urandom_range(0, 7));
            upc  = ($urandom_range(0, 3) == 0) ? ppc : ($urandom & 32'hFFFF_FF03);
            upc[IDX_W+1:2] = ($urandom_range(0, 3) == 0) ? ppc[IDX_W+1:2] : IDX_W'($urandom_range(0, 7));
            drive(preq, ppc, uv, upc, ut, up);
            total += 3;
            if (pred_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, pred_valid, exp_valid); end
            if (pred_taken !== exp_taken) begin bad++; $display("FAIL rnd_taken n=%0d got=%b exp=%b", n, pred_taken, exp_taken); end
            if (mispredict !== exp_mis) begin bad++; $display("FAIL rnd_mis n=%0d got=%b exp=%b", n, mispredict, exp_mis); end
`ifdef BP_PERF_CNT_EN
            total += 2;
            if (perf_branches !== 32'(exp_branches)) begin bad++; $display("FAIL rnd_perf_br got=%0d exp=%0d", perf_branches, exp_branches); end
            if (perf_mispred !== 32'(exp_mispred)) begin bad++; $display("FAIL rnd_perf_mp got=%0d exp=%0d", perf_mispred, exp_mispred); end
`endif
        end
        $display("test_random: 400 cycles");
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(0, 0, 1, 32'h10, 1, 1);
        drive(0, 0, 1, 32'h10, 1, 1);
        drive(1, 32'h10, 1, 32'h20, 1, 0);
        total += 2;
        if (mispredict !== 1'b1) begin bad++; $display("FAIL pre_arst_mis got=%b exp=1", mispredict); end
        if (pred_taken !== 1'b1) begin bad++; $display("FAIL pre_arst_taken got=%b exp=1", pred_taken); end
        #2;
        rst_n = 1'b0;
        #1;
        total += 3;
        if (pred_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", pred_valid); end
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL arst_taken got=%b exp=0", pred_taken); end
        if (mispredict !== 1'b0) begin bad++; $display("FAIL arst_mis got=%b exp=0", mispredict); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h10, 1, 32'h10, 0, 0);
        total++;
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL arst_entry got=%b exp=0", pred_taken); end
        for (int i = 0; i < ENTRIES; i++) begin
            drive(1, 32'(i * 4), 0, 0, 0, 0);
            total++;
            if (pred_taken !== exp_taken) begin bad++; $display("FAIL arst_scan idx=%0d got=%b exp=%b", i, pred_taken, exp_taken); end
        end
        $display("test_async_reset: done");
    endtask

`ifdef BP_PERF_CNT_EN
    task automatic test_perf();
        bit ut [5] = '{1, 0, 1, 1, 0};
        bit up [5] = '{1, 1, 1, 0, 0};
        apply_reset();
        for (int k = 0; k < 5; k++) drive(0, 0, 1, 32'(k * 8), ut[k], up[k]);
        total += 2;
        if (perf_branches !== 32'd5) begin bad++; $display("FAIL perf_branches got=%0d exp=5", perf_branches); end
        if (perf_mispred !== 32'd2) begin bad++; $display("FAIL perf_mispred got=%0d exp=2", perf_mispred); end
        $display("test_perf: branches=%0d mispred=%0d", perf_branches, perf_mispred);
    endtask
`endif

    initial begin
        test_reset();
        test_saturation();
        test_bypass();
        test_alias();
        test_mispredict();
        test_random();
        test_async_reset();
`ifdef BP_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side direction predictor; the front end of the branch-resolution path.
- Supplies a predicted taken/not-taken bit for a fetch PC.
- Trains a table of 2-bit saturating counters from the resolved outcome produced by the execute-stage branch comparator.
- Flags mispredictions so the pipeline control logic can flush and redirect.

Parameters:
- IDX_W, 6, index width; table holds ENTRIES = 2**IDX_W counters (legal 2..10).
- INIT_CTR, 2'b01, counter value loaded into every entry at reset (weakly not-taken).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- pred_req  input  1  prediction request from fetch this cycle
- pred_pc  input  32  PC of the fetched instruction
- pred_valid  output  1  prediction result valid (one cycle after pred_req)
- pred_taken  output  1  predicted direction, 1 = taken
- upd_valid  input  1  resolved conditional branch from execute this cycle
- upd_pc  input  32  PC of the resolved branch
- upd_taken  input  1  actual outcome from the branch comparator
- upd_pred  input  1  direction that was predicted for this branch
- mispredict  output  1  one-cycle pulse: resolved outcome differed from prediction

Behaviour:
- Index: idx = pc[IDX_W+1:2]. PC bits [1:0] are ignored; upper bits alias.
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset, asserted at any time including mid-operation:
  - all ENTRIES counters = INIT_CTR;
  - pred_valid = 0, pred_taken = 0, mispredict = 0;
  - in-flight requests and updates are discarded.
- Prediction, latency 1:
  - at the edge where pred_req = 1, register pred_valid = 1 and pred_taken = ctr[idx(pred_pc)][1];
  - where pred_req = 0, pred_valid = 0 and pred_taken holds its last value.
- Update:
  - at the edge where upd_valid = 1, ctr[idx(upd_pc)] moves toward the outcome;
  - taken: increment, saturating at 2'b11; not-taken: decrement, saturating at 2'b00;
  - no wrap-around in either direction.
- Mispredict:
  - registered; mispredict = upd_valid & (upd_taken ^ upd_pred), visible the cycle after the update;
  - de-asserts the following cycle unless another mispredicting update arrives;
  - back-to-back mispredicting updates hold it high continuously.
- Simultaneous request and update, same index: the prediction uses the post-update counter value (write-first bypass).
- Simultaneous request and update, different index: both proceed independently, with no stall.
- One update port only; at most one counter changes per cycle.
- No stall or backpressure; the block accepts a request and an update every cycle.
- Counter state meaning: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Predicted direction = MSB.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined, the block adds two outputs:
  - perf_branches[31:0]: increments on every upd_valid;
  - perf_mispred[31:0]: increments on every mispredicting update.
- Both counters reset to 0 and wrap modulo 2^32.
- Both update on the same edge as the table.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then pred_req=1, pred_pc=0x100 → next cycle pred_valid=1, pred_taken=0 (counter 01).
- upd_valid with upd_pc=0x100, upd_taken=1 twice, then predict 0x100 → pred_taken=1, entry=11. A third taken update keeps the entry at 11; three not-taken updates bring it to 00 and hold at 00 after a fourth.
- Same-cycle pred_req and upd_valid, both pc=0x200, upd_taken=1, entry 01 → pred_taken=1 (bypass). Repeat with upd_pc=0x204 → pred_taken=0.
- Aliasing with IDX_W=6: train pc=0x004 to 11, then predict pc=0x104 → pred_taken=1 (same index 1).
- Mispredict: upd_valid, upd_taken=1, upd_pred=0 → mispredict=1 for exactly one cycle. upd_taken=0, upd_pred=0 → mispredict stays 0.
- Assert rst_n=0 asynchronously mid-stream while mispredict=1 and entries are trained → outputs 0 immediately, all entries back to 01. With BP_PERF_CNT_EN defined, 5 updates with 2 mispredicts → perf_branches=5, perf_mispred=2.
